// File: rtl/hack_fetch_unit_if.sv
// rtl/hack_fetch_unit_if.sv - ROM fetch, instruction hand-off and status signals of the Hack fetch unit
interface hack_fetch_unit_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic              rom_req_valid;
  logic              rom_req_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rsp_valid;
  logic [DATA_W-1:0] rom_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [CNT_W-1:0]  retired_cnt;
  logic              spurious_rsp;

  modport master (
    output rom_req_valid, rom_addr, instr_valid, instr, instr_pc, retired_cnt, spurious_rsp,
    input  rom_req_ready, rom_rsp_valid, rom_rsp_data, instr_ready, br_taken, br_target
  );

  modport slave (
    input  rom_req_valid, rom_addr, instr_valid, instr, instr_pc, retired_cnt, spurious_rsp,
    output rom_req_ready, rom_rsp_valid, rom_rsp_data, instr_ready, br_taken, br_target
  );
endinterface

// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU fetch sequencer: one outstanding ROM fetch, PC update on retire
module hack_fetch_unit #(
  parameter int          ADDR_W    = 15,
  parameter int          DATA_W    = 16,
  parameter int unsigned RESET_VEC = 0,
  parameter int          CNT_W     = 32
) (
  input logic             clk,
  input logic             reset,
  hack_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              spur_q, spur_d;
  logic              retire;
  logic              rsp_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (bus.rom_req_ready) state_d = S_WAIT;
      S_WAIT:  if (bus.rom_rsp_valid) state_d = S_HOLD;
      S_HOLD:  if (bus.instr_ready)   state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    bus.rom_req_valid = (state_q == S_REQ);
    bus.instr_valid   = (state_q == S_HOLD);
  end

  // A response is only meaningful while waiting; anything else is dropped and flagged.
  always_comb begin
    retire     = (state_q == S_HOLD) && bus.instr_ready;
    rsp_accept = (state_q == S_WAIT) && bus.rom_rsp_valid;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = cnt_q;
    spur_d     = spur_q | (bus.rom_rsp_valid && (state_q != S_WAIT));
    if (rsp_accept) begin
      instr_d    = bus.rom_rsp_data;
      instr_pc_d = pc_q;
    end
    if (retire) begin
      pc_d  = bus.br_taken ? bus.br_target : pc_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= ADDR_W'(RESET_VEC);
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
      spur_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cnt_q      <= cnt_d;
      spur_q     <= spur_d;
    end
  end

  assign bus.rom_addr     = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.retired_cnt  = cnt_q;
  assign bus.spurious_rsp = spur_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb/tb_hack_fetch_unit.sv - randomized bench for hack_fetch_unit against a transaction-level model
module tb_hack_fetch_unit;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 32;
  localparam int PC_MOD  = 1 << ADDR_W;
  localparam int PH_REQ  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_HOLD = 2;

  logic clk = 1'b0;
  logic reset;

  hack_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  hack_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VEC(0), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what the fetch unit is doing, in terms of the fetch protocol.
  int     m_phase, m_pc, m_ipc, m_instr, m_spur, rsp_wait;
  longint m_cnt;

  int ready_pct = 100, iready_pct = 100, taken_pct = 0, spur_pct = 0, reset_permil = 0;
  int dly_min = 0, dly_max = 0;
  bit f_reset = 0, f_iready = 0, f_taken = 0, f_spur = 0;
  int f_target = 0;
  int dut_hs = 0;

  logic [15:0] t1_instr [3] = '{16'h0005, 16'hEC10, 16'h0007};

  function automatic logic [15:0] rom_word(input int a);
    int unsigned x;
    if (a == 0) return 16'h0005;
    if (a == 1) return 16'hEC10;
    if (a == 2) return 16'h0007;
    x = a * 40503;
    return x[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = PH_REQ; m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_spur = 0;
    end else if (m_phase == PH_REQ) begin
      if (bus.rom_rsp_valid) m_spur = 1;
      if (bus.rom_req_ready) begin
        m_phase  = PH_WAIT;
        rsp_wait = $urandom_range(dly_max, dly_min);
      end
    end else if (m_phase == PH_WAIT) begin
      if (bus.rom_rsp_valid) begin
        m_instr = int'(bus.rom_rsp_data);
        m_ipc   = m_pc;
        m_phase = PH_HOLD;
      end
    end else begin
      if (bus.rom_rsp_valid) m_spur = 1;
      if (bus.instr_ready) begin
        m_pc    = bus.br_taken ? int'(bus.br_target) : (m_pc + 1) % PC_MOD;
        m_cnt   = (m_cnt + 1) % 64'h1_0000_0000;
        m_phase = PH_REQ;
      end
    end
  endtask

  task automatic drive();
    reset             = f_reset || ($urandom_range(999) < reset_permil);
    bus.rom_req_ready = ($urandom_range(99) < ready_pct);
    bus.instr_ready   = f_iready || ($urandom_range(99) < iready_pct);
    bus.br_taken      = f_iready ? f_taken : ($urandom_range(99) < taken_pct);
    bus.br_target     = f_iready ? ADDR_W'(f_target) : ADDR_W'($urandom_range(PC_MOD - 1));
    if (m_phase == PH_WAIT) begin
      bus.rom_rsp_valid = (rsp_wait == 0);
      bus.rom_rsp_data  = (rsp_wait == 0) ? rom_word(m_pc) : 16'($urandom);
      if (rsp_wait != 0) rsp_wait--;
    end else begin
      bus.rom_rsp_valid = f_spur || ($urandom_range(99) < spur_pct);
      bus.rom_rsp_data  = f_spur ? 16'hDEAD : 16'($urandom);
    end
  endtask

  task automatic compare();
    chk("rom_req_valid", bus.rom_req_valid, m_phase == PH_REQ);
    chk("rom_addr", bus.rom_addr, m_pc);
    chk("instr_valid", bus.instr_valid, m_phase == PH_HOLD);
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("retired_cnt", bus.retired_cnt, m_cnt);
    chk("spurious_rsp", bus.spurious_rsp, m_spur);
    if (bus.rom_req_valid && bus.rom_req_ready && !reset) dut_hs++;
  endtask

  initial begin
    reset = 1'b1;
    bus.rom_req_ready = 0; bus.rom_rsp_valid = 0; bus.rom_rsp_data = '0;
    bus.instr_ready = 0; bus.br_taken = 0; bus.br_target = '0;
    m_phase = PH_REQ; m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_spur = 0; rsp_wait = 0;
    forever begin
      @(posedge clk);
      model_step();
      #1 drive();
      #4 compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic do_reset();
    f_reset = 1;
    @(posedge clk); #2;
    f_reset = 0;
    step();
  endtask

  task automatic retire_once(input bit tk, input int tgt);
    f_iready = 1; f_taken = tk; f_target = tgt;
    @(posedge clk); #2;
    f_iready = 0; f_taken = 0;
    step();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 200; i++) begin
      if (m_phase == ph) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_phase: phase %0d not reached within 200 cycles", ph);
  endtask

  int hs0;

  initial begin
    do_reset();
    chk("reset rom_req_valid", bus.rom_req_valid, 1);
    chk("reset rom_addr", bus.rom_addr, 0);
    chk("reset instr_valid", bus.instr_valid, 0);
    chk("reset instr", bus.instr, 0);
    chk("reset retired_cnt", bus.retired_cnt, 0);
    chk("reset spurious_rsp", bus.spurious_rsp, 0);

    // Zero-wait ROM, always retiring, never jumping.
    step();
    chk("t1 latency not yet valid", bus.instr_valid, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) step(); else repeat (3) step();
      chk("t1 instr_valid", bus.instr_valid, 1);
      chk("t1 instr", bus.instr, t1_instr[k]);
      chk("t1 instr_pc", bus.instr_pc, k);
    end
    ready_pct = 0; iready_pct = 0; dly_min = 3; dly_max = 3;
    step();
    chk("t1 retired_cnt", bus.retired_cnt, 3);
    chk("t1 rom_addr", bus.rom_addr, 3);

    // Stalled request, slow response.
    hs0 = dut_hs;
    for (int i = 0; i < 4; i++) begin
      chk("t2 rom_addr stable", bus.rom_addr, 3);
      chk("t2 req held", bus.rom_req_valid, 1);
      chk("t2 no instr", bus.instr_valid, 0);
      if (i < 3) step();
    end
    ready_pct = 100;
    wait_phase(PH_HOLD);
    chk("t2 one fetch", dut_hs - hs0, 1);
    chk("t2 instr", bus.instr, rom_word(3));
    chk("t2 instr_pc", bus.instr_pc, 3);

    // Jump decisions on retire only.
    dly_min = 0; dly_max = 0;
    retire_once(0, 0);
    chk("t3 rom_addr 4", bus.rom_addr, 4);
    wait_phase(PH_HOLD);
    retire_once(0, 0);
    wait_phase(PH_HOLD);
    chk("t3 instr_pc 5", bus.instr_pc, 5);
    taken_pct = 100;
    repeat (4) step();
    taken_pct = 0;
    chk("t3 taken ignored instr_pc", bus.instr_pc, 5);
    chk("t3 taken ignored valid", bus.instr_valid, 1);
    chk("t3 retired_cnt", bus.retired_cnt, 5);
    retire_once(0, 16'h0100);
    chk("t3 not taken rom_addr", bus.rom_addr, 6);
    wait_phase(PH_HOLD);
    retire_once(1, 16'h0100);
    chk("t3 taken rom_addr", bus.rom_addr, 16'h0100);

    // Long hold, then PC wrap.
    wait_phase(PH_HOLD);
    repeat (10) begin
      step();
      chk("t4 instr const", bus.instr, rom_word(16'h0100));
      chk("t4 instr_pc const", bus.instr_pc, 16'h0100);
      chk("t4 no request", bus.rom_req_valid, 0);
    end
    retire_once(1, 16'h7FFF);
    chk("t4 rom_addr 7fff", bus.rom_addr, 16'h7FFF);
    wait_phase(PH_HOLD);
    retire_once(0, 16'h1234);
    chk("t4 wrap rom_addr", bus.rom_addr, 0);
    chk("t4 retired_cnt", bus.retired_cnt, 9);

    // Spurious response while holding.
    wait_phase(PH_HOLD);
    f_spur = 1;
    @(posedge clk); #2;
    f_spur = 0;
    step();
    chk("t5 spurious set", bus.spurious_rsp, 1);
    chk("t5 instr kept", bus.instr, 16'h0005);
    chk("t5 still holding", bus.instr_valid, 1);
    repeat (5) step();
    chk("t5 spurious sticky", bus.spurious_rsp, 1);
    do_reset();
    chk("t5 spurious cleared", bus.spurious_rsp, 0);

    // Reset while waiting, and reset colliding with a taken retire.
    dly_min = 6; dly_max = 6;
    wait_phase(PH_WAIT);
    do_reset();
    chk("t6 wait reset rom_addr", bus.rom_addr, 0);
    chk("t6 wait reset req", bus.rom_req_valid, 1);
    chk("t6 wait reset instr_valid", bus.instr_valid, 0);
    dly_min = 0; dly_max = 0;
    wait_phase(PH_HOLD);
    retire_once(0, 0);
    chk("t6 rom_addr 1", bus.rom_addr, 1);
    wait_phase(PH_HOLD);
    f_iready = 1; f_taken = 1; f_target = 16'h0200; f_reset = 1;
    @(posedge clk); #2;
    f_iready = 0; f_taken = 0; f_reset = 0;
    step();
    chk("t6 retire reset rom_addr", bus.rom_addr, 0);
    chk("t6 retire reset cnt", bus.retired_cnt, 0);
    chk("t6 retire reset req", bus.rom_req_valid, 1);

    // Randomized traffic checked every cycle by the compare process.
    for (int blk = 0; blk < 15; blk++) begin
      ready_pct    = $urandom_range(100, 30);
      iready_pct   = $urandom_range(100, 20);
      taken_pct    = $urandom_range(60, 0);
      spur_pct     = $urandom_range(5, 0);
      reset_permil = $urandom_range(8, 0);
      dly_min      = 0;
      dly_max      = $urandom_range(4, 0);
      repeat (200) step();
    end
    spur_pct = 0; reset_permil = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
